// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C segment blocks.
// Holds the arbiter state encoding, requester indices and the round-robin pick.
package i2c_pkg;

    typedef enum logic [1:0] {
        StWait  = 2'd0,
        StIdle  = 2'd1,
        StOwned = 2'd2,
        StBusy  = 2'd3
    } arb_state_e;

    localparam int unsigned REQ_FPGA = 0;
    localparam int unsigned REQ_MCU  = 1;

    // One-hot grant for a request vector; a tie goes to the requester that did not own last.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
        logic [1:0] gnt;
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        return gnt;
    endfunction

endpackage

// File: rtl/i2c_cond_detect.sv
// Synchronizes raw SCL/SDA and decodes START/STOP conditions from consecutive samples.
// START/STOP are single-cycle pulses aligned with the synchronized sample.
module i2c_cond_detect #(
    parameter int unsigned SyncStages = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_o,
    output logic sda_o,
    output logic start_o,
    output logic stop_o
);

    logic [SyncStages-1:0] scl_sync_q, scl_sync_d;
    logic [SyncStages-1:0] sda_sync_q, sda_sync_d;
    logic                  scl_prev_q, scl_prev_d;
    logic                  sda_prev_q, sda_prev_d;

    always_comb begin
        scl_sync_d = {scl_sync_q[SyncStages-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SyncStages-2:0], sda_i};
        scl_prev_d = scl_sync_q[SyncStages-1];
        sda_prev_d = sda_sync_q[SyncStages-1];
    end

    // Lines idle high, so resetting to 1 keeps a reset from looking like a START.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    always_comb begin
        scl_o   = scl_sync_q[SyncStages-1];
        sda_o   = sda_sync_q[SyncStages-1];
        start_o = scl_prev_q & scl_o &  sda_prev_q & ~sda_o;
        stop_o  = scl_prev_q & scl_o & ~sda_prev_q &  sda_o;
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin ownership arbiter for the shared FPGA/MCU I2C segment.
// Grants only after a bus-free interval and revokes ownership on a stuck line.
module i2c_bus_arbiter
    import i2c_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned FREE_CYCLES  = 240,
    parameter int unsigned STUCK_CYCLES = 1048576
) (
    input  logic       iCLK,
    input  logic       iRESET,
    input  logic       iSCL,
    input  logic       iSDA,
    input  logic [1:0] iREQ,
    output logic [1:0] oGNT,
    output logic       oBRIDGE_EN,
    output logic       oBUSY,
    output logic       oSTUCK
);

    localparam int unsigned FreeW  = (FREE_CYCLES  > 1) ? $clog2(FREE_CYCLES)  : 1;
    localparam int unsigned StuckW = (STUCK_CYCLES > 1) ? $clog2(STUCK_CYCLES) : 1;
    localparam logic [FreeW-1:0]  FreeMax  = FreeW'(FREE_CYCLES - 1);
    localparam logic [StuckW-1:0] StuckMax = StuckW'(STUCK_CYCLES - 1);

    logic scl_s, sda_s, start_s, stop_s;

    i2c_cond_detect #(
        .SyncStages (SYNC_STAGES)
    ) u_cond_detect (
        .clk_i   (iCLK),
        .rst_i   (iRESET),
        .scl_i   (iSCL),
        .sda_i   (iSDA),
        .scl_o   (scl_s),
        .sda_o   (sda_s),
        .start_o (start_s),
        .stop_o  (stop_s)
    );

    arb_state_e        state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              last_q, last_d;
    logic [FreeW-1:0]  free_cnt_q, free_cnt_d;
    logic [StuckW-1:0] stuck_cnt_q, stuck_cnt_d;
    logic              stuck_q, stuck_d;

    logic       line_idle;
    logic       stuck_timeout;
    logic [1:0] pick;

    always_comb begin
        line_idle     = scl_s & sda_s;
        stuck_timeout = ~line_idle & (stuck_cnt_q == StuckMax);
        pick          = rr_pick(iREQ, last_q);
    end

    // Stuck counter saturates at its terminal value so a long hold never wraps to "not stuck".
    always_comb begin
        stuck_cnt_d = stuck_cnt_q;
        if (line_idle) begin
            stuck_cnt_d = '0;
        end else if (stuck_cnt_q != StuckMax) begin
            stuck_cnt_d = stuck_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        free_cnt_d = free_cnt_q;
        stuck_d    = stuck_q;

        unique case (state_q)
            StWait: begin
                if (start_s || !line_idle) begin
                    free_cnt_d = '0;
                end else if (free_cnt_q == FreeMax) begin
                    free_cnt_d = '0;
                    state_d    = StIdle;
                end else begin
                    free_cnt_d = free_cnt_q + 1'b1;
                end
            end
            StIdle: begin
                // A START coinciding with a request is taken to be the requester's own.
                if (|iREQ) begin
                    gnt_d   = pick;
                    last_d  = pick[REQ_MCU];
                    state_d = StOwned;
                end else if (start_s) begin
                    state_d = StBusy;
                end
            end
            StOwned: begin
                if (!(|(iREQ & gnt_q))) begin
                    gnt_d      = 2'b00;
                    free_cnt_d = '0;
                    state_d    = StWait;
                end
            end
            StBusy: begin
                if (stop_s) begin
                    free_cnt_d = '0;
                    state_d    = StWait;
                end
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = StWait;
            end
        endcase

        // Stuck handling overrides the normal transitions; release and timeout are exclusive.
        if (stuck_q && line_idle) begin
            stuck_d    = 1'b0;
            gnt_d      = 2'b00;
            free_cnt_d = '0;
            state_d    = StWait;
        end
        if (stuck_timeout) begin
            stuck_d = 1'b1;
            gnt_d   = 2'b00;
            state_d = StBusy;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q     <= StWait;
            gnt_q       <= 2'b00;
            last_q      <= 1'b1;
            free_cnt_q  <= '0;
            stuck_cnt_q <= '0;
            stuck_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            free_cnt_q  <= free_cnt_d;
            stuck_cnt_q <= stuck_cnt_d;
            stuck_q     <= stuck_d;
        end
    end

    always_comb begin
        oGNT       = gnt_q;
        oBRIDGE_EN = gnt_q[REQ_MCU];
        oBUSY      = (state_q != StIdle);
        oSTUCK     = stuck_q;
    end

endmodule
